// File: rtl/pid_gen_pkg.sv
// -----------------------------------------------------------------------------
// pid_gen_pkg
// Shared definitions for the parametrised PID steering controller:
//   - DEF_* : default parameter values
//   - sat_signed #(IW, OW)::sat(v) : clamps a signed IW-bit value into the
//     signed OW-bit range (requires IW > OW)
//   - pid_terms_t : the three PID terms, kept together for debug taps
// -----------------------------------------------------------------------------
package pid_gen_pkg;

    localparam int DEF_ERR_W     = 12;
    localparam int DEF_SAT_W     = 10;
    localparam int DEF_SPD_W     = 11;
    localparam int DEF_INT_W     = 15;
    localparam int DEF_I_SHIFT   = 6;
    localparam int DEF_DSAT_W    = 8;
    localparam int DEF_D_DEPTH   = 3;
    localparam int DEF_P_COEFF   = 16;
    localparam int DEF_D_COEFF   = 7;
    localparam int DEF_PID_W     = 14;
    localparam int DEF_OUT_SHIFT = 3;
    localparam int DEF_SLEW_MAX  = 32;

    typedef struct packed {
        logic signed [31:0] p;
        logic signed [31:0] i;
        logic signed [31:0] d;
    } pid_terms_t;

    virtual class sat_signed #(parameter int IW = 32, parameter int OW = 16);
        static function logic signed [OW-1:0] sat(input logic signed [IW-1:0] v);
            logic signed [IW-1:0] hi;
            logic signed [IW-1:0] lo;
            hi = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            lo = ~hi;
            if (v > hi) begin
                sat = hi[OW-1:0];
            end else if (v < lo) begin
                sat = lo[OW-1:0];
            end else begin
                sat = v[OW-1:0];
            end
        endfunction
    endclass

endpackage

// File: rtl/pid_spd_out.sv
// -----------------------------------------------------------------------------
// pid_spd_out
// Output stage for one wheel: frwrd +/- (pid >>> OUT_SHIFT), clamped to
// [0, 2^(SPD_W-1)-1], forced to 0 while not moving, then registered on upd.
// Optional slew limiting when PID_SLEW_LIMIT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   moving    : low forces the updated value to 0 (bypasses slew limit)
//   upd       : load a new output value this cycle
//   frwrd     : unsigned forward speed
//   pid       : signed PID sum
//   spd       : registered wheel speed
// Parameter NEG selects subtraction (right wheel) instead of addition.
// -----------------------------------------------------------------------------
module pid_spd_out
    import pid_gen_pkg::*;
#(
    parameter int SPD_W     = DEF_SPD_W,
    parameter int PID_W     = DEF_PID_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int SLEW_MAX  = DEF_SLEW_MAX,
    parameter bit NEG       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    moving,
    input  logic                    upd,
    input  logic [SPD_W-2:0]        frwrd,
    input  logic signed [PID_W-1:0] pid,
    output logic [SPD_W-1:0]        spd
);

    localparam int SPD_MAX = (1 << (SPD_W-1)) - 1;

    if (SLEW_MAX < 1) begin : g_slew_chk
        $error("SLEW_MAX must be positive");
    end

    logic [SPD_W-1:0] spd_q;
    logic [SPD_W-1:0] spd_d;
    int               adj;
    int               tgt;
`ifdef PID_SLEW_LIMIT_EN
    int               delta;
`endif

    always_comb begin
        adj = int'(pid) >>> OUT_SHIFT;
        tgt = NEG ? (int'(frwrd) - adj) : (int'(frwrd) + adj);
        if (tgt < 0) begin
            tgt = 0;
        end else if (tgt > SPD_MAX) begin
            tgt = SPD_MAX;
        end
        if (!moving) begin
            tgt = 0;
        end
`ifdef PID_SLEW_LIMIT_EN
        delta = tgt - int'(spd_q);
        if (moving) begin
            if (delta > SLEW_MAX) begin
                tgt = int'(spd_q) + SLEW_MAX;
            end else if (delta < -SLEW_MAX) begin
                tgt = int'(spd_q) - SLEW_MAX;
            end
        end
`endif
        spd_d = upd ? SPD_W'(tgt) : spd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spd_q <= '0;
        end else begin
            spd_q <= spd_d;
        end
    end

    assign spd = spd_q;

endmodule

// File: rtl/pid_ctrl_gen.sv
// -----------------------------------------------------------------------------
// pid_ctrl_gen
// Parametrised PID steering controller. Three-stage pipeline:
//   S0: saturate error, register valid
//   S1: P/I/D terms, integrator with anti-windup, derivative history, PID sum
//   S2: per-wheel speed (pid_spd_out x2), spd_vld strobe
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   moving             : low zeroes outputs and clears the integrator
//   err_vld, error     : signed heading error sample and its strobe
//   frwrd              : unsigned forward speed (SPD_W-1 bits)
//   lft_spd, rght_spd  : registered wheel speeds
//   spd_vld            : one-cycle strobe for new wheel speeds
// Build option: define PID_SLEW_LIMIT_EN to limit each output step to SLEW_MAX.
// -----------------------------------------------------------------------------
module pid_ctrl_gen
    import pid_gen_pkg::*;
#(
    parameter int ERR_W     = DEF_ERR_W,
    parameter int SAT_W     = DEF_SAT_W,
    parameter int SPD_W     = DEF_SPD_W,
    parameter int INT_W     = DEF_INT_W,
    parameter int I_SHIFT   = DEF_I_SHIFT,
    parameter int DSAT_W    = DEF_DSAT_W,
    parameter int D_DEPTH   = DEF_D_DEPTH,
    parameter int P_COEFF   = DEF_P_COEFF,
    parameter int D_COEFF   = DEF_D_COEFF,
    parameter int PID_W     = DEF_PID_W,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int SLEW_MAX  = DEF_SLEW_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [SPD_W-2:0]        frwrd,
    output logic [SPD_W-1:0]        lft_spd,
    output logic [SPD_W-1:0]        rght_spd,
    output logic                    spd_vld
);

    localparam int INT_MAX = (1 << (INT_W-1)) - 1;
    localparam int INT_MIN = -(1 << (INT_W-1));

    if (D_DEPTH < 1) begin : g_depth_chk
        $error("D_DEPTH must be at least 1");
    end

    logic signed [SAT_W-1:0] err_sat_q, err_sat_d;
    logic                    vld0_q, vld0_d;
    logic                    vld1_q, vld1_d;
    logic                    spd_vld_q, spd_vld_d;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic signed [SAT_W-1:0] hist_q [D_DEPTH];
    logic signed [SAT_W-1:0] hist_d [D_DEPTH];
    logic signed [PID_W-1:0] pid_q, pid_d;
    logic signed [SAT_W:0]   diff;
    int                      integ_sum;
    pid_terms_t              terms;

    always_comb begin
        err_sat_d = sat_signed#(ERR_W, SAT_W)::sat(error);
        vld0_d    = err_vld;
        vld1_d    = vld0_q;
        spd_vld_d = vld1_q;

        // One extra bit so the difference of two SAT_W values never wraps
        diff = $signed({err_sat_q[SAT_W-1], err_sat_q})
             - $signed({hist_q[D_DEPTH-1][SAT_W-1], hist_q[D_DEPTH-1]});

        terms.p = (int'(err_sat_q) * P_COEFF) >>> 1;
        terms.i = int'(integ_q) >>> I_SHIFT;
        terms.d = int'(sat_signed#(SAT_W+1, DSAT_W)::sat(diff)) * D_COEFF;
        pid_d   = sat_signed#(32, PID_W)::sat(terms.p + terms.i + terms.d);

        // Anti-windup: an add that would leave the INT_W range is dropped
        integ_sum = int'(integ_q) + int'(err_sat_q);
        integ_d   = integ_q;
        if (!moving) begin
            integ_d = '0;
        end else if (vld0_q && (integ_sum >= INT_MIN) && (integ_sum <= INT_MAX)) begin
            integ_d = INT_W'(integ_sum);
        end

        hist_d = hist_q;
        if (vld0_q) begin
            hist_d[0] = err_sat_q;
            for (int k = 1; k < D_DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sat_q <= '0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
            spd_vld_q <= 1'b0;
            integ_q   <= '0;
            pid_q     <= '0;
            hist_q    <= '{default: '0};
        end else begin
            err_sat_q <= err_sat_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
            spd_vld_q <= spd_vld_d;
            integ_q   <= integ_d;
            pid_q     <= pid_d;
            hist_q    <= hist_d;
        end
    end

    pid_spd_out #(
        .SPD_W    (SPD_W),
        .PID_W    (PID_W),
        .OUT_SHIFT(OUT_SHIFT),
        .SLEW_MAX (SLEW_MAX),
        .NEG      (1'b0)
    ) u_lft (
        .clk   (clk),
        .rst   (rst),
        .moving(moving),
        .upd   (vld1_q),
        .frwrd (frwrd),
        .pid   (pid_q),
        .spd   (lft_spd)
    );

    pid_spd_out #(
        .SPD_W    (SPD_W),
        .PID_W    (PID_W),
        .OUT_SHIFT(OUT_SHIFT),
        .SLEW_MAX (SLEW_MAX),
        .NEG      (1'b1)
    ) u_rght (
        .clk   (clk),
        .rst   (rst),
        .moving(moving),
        .upd   (vld1_q),
        .frwrd (frwrd),
        .pid   (pid_q),
        .spd   (rght_spd)
    );

    assign spd_vld = spd_vld_q;

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_pid_ctrl_gen
// Self-checking bench for pid_ctrl_gen at default parameters. A sample-level
// reference model runs alongside the DUT; directed vectors and hand-written
// sequences cover saturation, anti-windup, moving drop, mid-stream reset and
// (when PID_SLEW_LIMIT_EN is defined) slew limiting.
// -----------------------------------------------------------------------------
module tb_pid_ctrl_gen;

    localparam int SLEW  = 32;
    localparam int DEPTH = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               moving;
    logic               err_vld;
    logic signed [11:0] error;
    logic [9:0]         frwrd;
    logic [10:0]        lft_spd;
    logic [10:0]        rght_spd;
    logic               spd_vld;

    int checks = 0;
    int errors = 0;

    pid_ctrl_gen dut (
        .clk     (clk),
        .rst     (rst),
        .moving  (moving),
        .err_vld (err_vld),
        .error   (error),
        .frwrd   (frwrd),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .spd_vld (spd_vld)
    );

    always #5 clk = ~clk;

    function automatic int sat(int v, int w);
        int hi = (1 << (w-1)) - 1;
        int lo = -(1 << (w-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int clamp_spd(int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic int slew_to(int cur, int tgt);
        if (tgt - cur > SLEW) return cur + SLEW;
        if (tgt - cur < -SLEW) return cur - SLEW;
        return tgt;
    endfunction

    function automatic int first_step(int tgt);
`ifdef PID_SLEW_LIMIT_EN
        return (tgt > SLEW) ? SLEW : tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sample level) ----------------
    typedef struct {
        int e;
        int pid;
        int age;
    } smp_t;

    smp_t inflight[$];
    int   m_hist[$];
    int   m_integ;
    int   m_lft;
    int   m_rght;
    bit   m_strobe;

    task automatic model_reset();
        inflight.delete();
        m_hist.delete();
        for (int k = 0; k < DEPTH; k++) m_hist.push_back(0);
        m_integ  = 0;
        m_lft    = 0;
        m_rght   = 0;
        m_strobe = 0;
    endtask

    task automatic model_edge();
        smp_t s;
        int   p, i, d, sum, tl, tr, sh;
        if (rst) begin
            model_reset();
            return;
        end
        m_strobe = 0;
        // sample whose PID sum is ready: produce wheel speeds
        if (inflight.size() > 0 && inflight[0].age == 1) begin
            s  = inflight.pop_front();
            sh = s.pid >>> 3;
            tl = clamp_spd(int'(frwrd) + sh);
            tr = clamp_spd(int'(frwrd) - sh);
            if (!moving) begin
                tl = 0;
                tr = 0;
            end
`ifdef PID_SLEW_LIMIT_EN
            if (moving) begin
                tl = slew_to(m_lft, tl);
                tr = slew_to(m_rght, tr);
            end
`endif
            m_lft    = tl;
            m_rght   = tr;
            m_strobe = 1;
        end
        // freshly saturated sample: form PID with the pre-update integrator
        if (inflight.size() > 0 && inflight[0].age == 0) begin
            p = inflight[0].e * 16 / 2;
            i = m_integ >>> 6;
            d = sat(inflight[0].e - m_hist[DEPTH-1], 8) * 7;
            inflight[0].pid = sat(p + i + d, 14);
            inflight[0].age = 1;
            sum = m_integ + inflight[0].e;
            if (moving && sum >= -16384 && sum <= 16383) m_integ = sum;
            m_hist.push_front(inflight[0].e);
            void'(m_hist.pop_back());
        end
        if (!moving) m_integ = 0;
        if (err_vld) begin
            s.e   = sat(int'(error), 10);
            s.pid = 0;
            s.age = 0;
            inflight.push_back(s);
        end
    endtask

    always @(posedge clk) begin
        model_edge();
        #1;
        chk("spd_vld", int'(spd_vld), int'(m_strobe));
        chk("lft_spd", int'(lft_spd), m_lft);
        chk("rght_spd", int'(rght_spd), m_rght);
        chk("integ", int'(dut.integ_q), m_integ);
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        mov;
        logic [9:0]  fw;
        logic [11:0] err;
        int          lft;
        int          rght;
    } vec_t;

    vec_t vec [8];

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        err_vld = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    initial begin
        int strobes;
        rst     = 1'b1;
        moving  = 1'b0;
        err_vld = 1'b0;
        error   = '0;
        frwrd   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        vec[0] = '{1'b1, 10'h100, 12'h7FF, 878, 0};
        vec[1] = '{1'b1, 10'h3FF, 12'h800, 399, 1023};
        vec[2] = '{1'b1, 10'h200, 12'h000, 512, 512};
        vec[3] = '{1'b1, 10'h200, 12'h00A, 530, 494};
        vec[4] = '{1'b1, 10'h200, 12'hFF6, 493, 531};
        vec[5] = '{1'b0, 10'h200, 12'h064, 0, 0};
        vec[6] = '{1'b1, 10'h050, 12'h0C8, 391, 0};
        vec[7] = '{1'b1, 10'h3FF, 12'h7FF, 1023, 401};

        for (int k = 0; k < 8; k++) begin
            do_reset();
            moving  = vec[k].mov;
            frwrd   = vec[k].fw;
            error   = vec[k].err;
            err_vld = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_lat0", k), int'(spd_vld), 0);
            @(negedge clk);
            err_vld = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_lat1", k), int'(spd_vld), 0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_vld", k), int'(spd_vld), 1);
            chk($sformatf("tbl%0d_lft", k), int'(lft_spd), first_step(vec[k].lft));
            chk($sformatf("tbl%0d_rght", k), int'(rght_spd), first_step(vec[k].rght));
        end

        // anti-windup: 511 per update caps at 32*511
        do_reset();
        moving  = 1'b1;
        frwrd   = 10'h100;
        error   = 12'h1FF;
        err_vld = 1'b1;
        repeat (40) @(negedge clk);
        chk("windup_integ", int'(dut.integ_q), 16352);

        // moving drop mid-stream
        moving = 1'b0;
        @(posedge clk); #1;
        chk("drop_integ", int'(dut.integ_q), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("drop_vld", int'(spd_vld), 1);
            chk("drop_lft", int'(lft_spd), 0);
            chk("drop_rght", int'(rght_spd), 0);
        end
        chk("drop_hist0", int'(dut.hist_q[0]), 511);
        chk("drop_hist2", int'(dut.hist_q[2]), 511);
        @(negedge clk);
        err_vld = 1'b0;
        moving  = 1'b1;
        repeat (4) @(negedge clk);

        // reset with samples in flight
        err_vld = 1'b1;
        error   = 12'h050;
        frwrd   = 10'h1F0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        err_vld = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        strobes = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (spd_vld) strobes++;
        end
        chk("rst_strobes", strobes, 0);
        chk("rst_lft", int'(lft_spd), 0);
        chk("rst_rght", int'(rght_spd), 0);

`ifdef PID_SLEW_LIMIT_EN
        // slew: left output ramps by SLEW per update toward ~878
        do_reset();
        moving  = 1'b1;
        frwrd   = 10'h100;
        error   = 12'h7FF;
        err_vld = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("slew_step%0d", k), int'(lft_spd), SLEW * k);
        end
        @(negedge clk);
        err_vld = 1'b0;
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 99) == 0);
            moving  = ($urandom_range(0, 15) != 0);
            err_vld = ($urandom_range(0, 3) != 0);
            error   = 12'(int'($urandom_range(0, 1400)) - 700);
            if ($urandom_range(0, 7) == 0) error = 12'($urandom);
            frwrd   = 10'($urandom);
        end
        @(negedge clk);
        err_vld = 1'b0;
        rst     = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pid_ctrl_gen.md
# pid_ctrl_gen

Parametrised second-generation PID steering controller. Takes a signed heading error and a forward-speed command and produces left/right motor duty values, pipelined with an explicit output-valid strobe. It adds the following over the fixed-width controller:
- generic widths and gains;
- a configurable-depth derivative history;
- two-sided output clamping;
- optional slew limiting.

It sits between the heading-error generator and the motor PWM drivers.

## Interface
- ERR_W, 12, width of raw `error` input
- SAT_W, 10, saturated error width
- SPD_W, 11, speed output width (`frwrd` is SPD_W-1 bits)
- INT_W, 15, integrator width
- I_SHIFT, 6, integrator right-shift to form I term
- DSAT_W, 8, saturated derivative-difference width
- D_DEPTH, 3, derivative history depth in valid samples (≥1)
- P_COEFF, 16, unsigned proportional gain
- D_COEFF, 7, unsigned derivative gain
- PID_W, 14, PID sum width
- OUT_SHIFT, 3, PID-to-speed right-shift
- SLEW_MAX, 32, max output step per update (used only with PID_SLEW_LIMIT_EN)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- moving  in  1  enable; low zeroes outputs and clears the integrator
- err_vld  in  1  `error` valid strobe
- error  in  ERR_W  signed heading error
- frwrd  in  SPD_W-1  unsigned forward speed
- lft_spd  out  SPD_W  left speed, registered
- rght_spd  out  SPD_W  right speed, registered
- spd_vld  out  1  one-cycle strobe: new lft/rght_spd values

## Operation
- **S0 (every cycle):**
  - `err_sat_q` ← `error` saturated to SAT_W signed range.
  - `vld0_q` ← `err_vld`.
- **S1 terms:**
  - P = (`err_sat_q` × P_COEFF) >>> 1.
  - I = integrator >>> I_SHIFT, using the integrator value *before* this cycle's update.
  - D = sat_DSAT_W(`err_sat_q` − `hist[D_DEPTH-1]`) × D_COEFF.
- **S1 integrator and history:**
  - When `vld0_q` is high and `moving` is high, the integrator adds sign-extended `err_sat_q` unless the signed add overflows INT_W. On overflow the integrator holds (anti-windup).
  - `moving` low: integrator ← 0 (takes priority).
  - `hist` is a D_DEPTH shift register. It shifts in `err_sat_q` on `vld0_q`, independent of `moving`.
- **S1 register:**
  - `pid_q` ← P+I+D, saturated to PID_W signed.
  - `vld1_q` ← `vld0_q`.
- **S2:**
  - lft = `frwrd` + (`pid_q` >>> OUT_SHIFT); rght = `frwrd` − (`pid_q` >>> OUT_SHIFT).
  - Both are clamped to [0, 2^(SPD_W-1)−1], i.e. 0..1023 at defaults.
  - If `moving` is low, both outputs are 0.
  - Outputs update only when `vld1_q` is high, otherwise they hold.
  - `spd_vld` ← `vld1_q`.
- **Reset:** all pipeline registers, integrator, `hist`, `lft_spd`, `rght_spd` and `spd_vld` go to 0. A reset mid-stream discards all in-flight samples.

## Timing
- `err_vld` sampled at edge n → `spd_vld` high and new speeds visible in cycle n+3. Latency is 3 clocks.
- Full throughput: `err_vld` may be high every cycle.
- `moving` falling edge: the integrator clears at the next edge. Any output update produced while `moving` is low is 0.
- `moving` is not pipelined. S1 and S2 sample it combinationally in their own cycle.

## Configuration
- **PID_SLEW_LIMIT_EN defined:**
  - Each valid update limits |new − current| on each output to SLEW_MAX; values step by ±SLEW_MAX toward the target.
  - `moving` low bypasses the limiter, so outputs go immediately to 0.
- **Undefined:** outputs take the clamped target directly. SLEW_MAX is ignored.

## Structure
- Package `pid_gen_pkg` holds:
  - default parameter constants;
  - a `sat_signed` function (width-generic saturation via parameterised class or macro);
  - a `pid_terms_t` struct {p, i, d} for debug taps.
- Sub-module `pid_spd_out`: per-wheel S2 logic (add/sub, clamp, moving gate, optional slew, output register). It is instantiated twice, with the sign selected by a parameter.

## Test plan
All scenarios use default parameters.
1. **Positive saturation.** `rst` then `moving`=1, `frwrd`=0x100, single `err_vld` with `error`=0x7FF.
   - Expected: cycle +3 `spd_vld`=1, `lft_spd`=0x36E (878), `rght_spd`=0 (clamped).
   - Derivation: P=4088, I=0, D=889, PID=4977.
2. **Negative saturation.** `frwrd`=0x3FF, single `err_vld` with `error`=0x800 after reset.
   - Expected: `lft_spd`=399, `rght_spd`=0x3FF (clamped).
   - Derivation: PID=−4992, shifted value −624.
3. **Anti-windup.** `error`=0x1FF with `err_vld` held high, `moving`=1.
   - Expected: integrator reaches 16352 after 32 updates, then holds at 16352 (no wrap).
4. **Moving drop.** Drop `moving` mid-stream.
   - Expected: integrator = 0 next edge; subsequent `spd_vld` strobes carry 0/0; `hist` retains its values.
5. **Reset mid-operation.** Assert `rst` for 1 cycle with samples in flight.
   - Expected: outputs 0, `spd_vld` 0, and no strobe appears for the discarded samples.
6. **Slew limit.** With PID_SLEW_LIMIT_EN, repeat scenario 1.
   - Expected: `lft_spd` steps 32, 64, 96… on successive valid updates until reaching its target.
